// File: rtl/pbl_pkg.sv
// Shared definitions for the naval-battle board: grid geometry, game-mode
// encodings, the coordinate-input FSM states and the cell-index helper.
package pbl_pkg;

    localparam int N_COLS  = 5;
    localparam int N_LINES = 7;
    localparam int N_CELLS = N_COLS * N_LINES;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_PLACE  = 2'b01,
        MODE_ATTACK = 2'b10,
        MODE_REVIEW = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT_ACK,
        ST_RELEASE
    } coord_in_state_t;

    // Row-major cell number as used by the attack-matrix register bank.
    function automatic logic [5:0] cell_index(input logic [2:0] line, input logic [2:0] col);
        return 6'(line) * 6'(N_COLS) + 6'(col);
    endfunction

endpackage

// File: rtl/pbl_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one active-low
// pushbutton; emits a one-cycle press pulse on an accepted 1->0 transition.
module pbl_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic clr,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_b;
                cnt   <= '0;
                press <= ~sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pbl_coord_input.sv
// Cursor, shot history and shot-issue FSM for the attack phase; turns
// debounced button presses into one valid/ready shot per confirmation.
module pbl_coord_input
    import pbl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       button_count,
    input  logic       button_confirmation,
    input  logic [1:0] hh1,
    input  logic       shot_ready,
    output logic [2:0] coord_col,
    output logic [2:0] coord_line,
    output logic       shot_valid,
    output logic [5:0] shot_cell,
    output logic       dup_shot,
    output logic       busy
);

    localparam logic [2:0] LAST_COL  = 3'(N_COLS - 1);
    localparam logic [2:0] LAST_LINE = 3'(N_LINES - 1);

    coord_in_state_t      state, state_n;
    logic [1:0]           mode_meta;
    mode_t                mode_s;
    logic                 count_press, count_level_unused;
    logic                 confirm_press, confirm_level;
    logic [N_CELLS-1:0]   history, history_n;
    logic [2:0]           col_n, line_n;
    logic [5:0]           cell_n, cur_cell;
    logic                 valid_n, dup_n, busy_n, attack;

    pbl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_count (
        .clk    (clk),
        .clr    (clr),
        .button (button_count),
        .level  (count_level_unused),
        .press  (count_press)
    );

    pbl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
        .clk    (clk),
        .clr    (clr),
        .button (button_confirmation),
        .level  (confirm_level),
        .press  (confirm_press)
    );

    assign attack   = (mode_s == MODE_ATTACK);
    assign cur_cell = cell_index(coord_line, coord_col);

    always_ff @(posedge clk) begin
        if (clr) begin
            mode_meta  <= 2'b00;
            mode_s     <= MODE_IDLE;
            state      <= ST_IDLE;
            coord_col  <= '0;
            coord_line <= '0;
            shot_valid <= 1'b0;
            shot_cell  <= '0;
            dup_shot   <= 1'b0;
            busy       <= 1'b0;
            history    <= '0;
        end else begin
            mode_meta  <= hh1;
            mode_s     <= mode_t'(mode_meta);
            state      <= state_n;
            coord_col  <= col_n;
            coord_line <= line_n;
            shot_valid <= valid_n;
            shot_cell  <= cell_n;
            dup_shot   <= dup_n;
            busy       <= busy_n;
            history    <= history_n;
        end
    end

    // Confirm is tested before count so a simultaneous count press is dropped;
    // a pending shot is only left once the consumer has taken it.
    always_comb begin
        state_n   = state;
        col_n     = coord_col;
        line_n    = coord_line;
        valid_n   = shot_valid;
        cell_n    = shot_cell;
        dup_n     = 1'b0;
        history_n = history;
        if (mode_s == MODE_IDLE) history_n = '0;

        unique case (state)
            ST_IDLE: begin
                col_n  = '0;
                line_n = '0;
                if (attack) state_n = ST_SELECT;
            end
            ST_SELECT: begin
                if (!attack) begin
                    state_n = ST_IDLE;
                    col_n   = '0;
                    line_n  = '0;
                end else if (confirm_press) begin
                    if (history[cur_cell]) begin
                        dup_n   = 1'b1;
                        state_n = ST_RELEASE;
                    end else begin
                        cell_n  = cur_cell;
                        valid_n = 1'b1;
                        state_n = ST_WAIT_ACK;
                    end
                end else if (count_press) begin
                    if (coord_col == LAST_COL) begin
                        col_n  = '0;
                        line_n = (coord_line == LAST_LINE) ? 3'd0 : coord_line + 3'd1;
                    end else begin
                        col_n = coord_col + 3'd1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (shot_valid && shot_ready) begin
                    valid_n              = 1'b0;
                    history_n[shot_cell] = 1'b1;
                    if (attack) begin
                        state_n = ST_RELEASE;
                    end else begin
                        state_n = ST_IDLE;
                        col_n   = '0;
                        line_n  = '0;
                    end
                end
            end
            ST_RELEASE: begin
                if (!attack) begin
                    state_n = ST_IDLE;
                    col_n   = '0;
                    line_n  = '0;
                end else if (confirm_level) begin
                    state_n = ST_SELECT;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_WAIT_ACK) || (state_n == ST_RELEASE);
    end

endmodule

// File: tb/tb_pbl_coord_input.sv
// Directed bench for pbl_coord_input with a 4-cycle debounce: reset, cursor
// stepping, handshake, duplicate shots, simultaneous events and mid-shot clear.
module tb_pbl_coord_input;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       button_count;
    logic       button_confirmation;
    logic [1:0] hh1;
    logic       shot_ready;
    logic [2:0] coord_col;
    logic [2:0] coord_line;
    logic       shot_valid;
    logic [5:0] shot_cell;
    logic       dup_shot;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pbl_coord_input #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk                 (clk),
        .clr                 (clr),
        .button_count        (button_count),
        .button_confirmation (button_confirmation),
        .hh1                 (hh1),
        .shot_ready          (shot_ready),
        .coord_col           (coord_col),
        .coord_line          (coord_line),
        .shot_valid          (shot_valid),
        .shot_cell           (shot_cell),
        .dup_shot            (dup_shot),
        .busy                (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A clean press: low long enough to be accepted, then released long enough.
    task automatic press_counts(input int n);
        for (int i = 0; i < n; i++) begin
            button_count = 1'b0;
            tick(8);
            button_count = 1'b1;
            tick(8);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; hh1 = 2'b10; shot_ready = 1'b0;
        button_count = 1'b1; button_confirmation = 1'b1;
        tick(1);
        checks++; if (coord_col !== 3'd0) begin errors++; $display("[TB] FAIL reset_col got %0d want 0", coord_col); end
        checks++; if (coord_line !== 3'd0) begin errors++; $display("[TB] FAIL reset_line got %0d want 0", coord_line); end
        checks++; if (shot_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", shot_valid); end
        checks++; if (shot_cell !== 6'd0) begin errors++; $display("[TB] FAIL reset_cell got %0d want 0", shot_cell); end
        checks++; if (dup_shot !== 1'b0) begin errors++; $display("[TB] FAIL reset_dup got %b want 0", dup_shot); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        clr = 1'b0;
        tick(4);
        checks++; if ({coord_line, coord_col} !== 6'd0) begin errors++; $display("[TB] FAIL select_cursor got %0d/%0d want 0/0", coord_col, coord_line); end
    endtask

    task automatic test_cursor();
        press_counts(1);
        checks++; if (coord_col !== 3'd1 || coord_line !== 3'd0) begin errors++; $display("[TB] FAIL step1 got %0d/%0d want 1/0", coord_col, coord_line); end
        press_counts(3);
        checks++; if (coord_col !== 3'd4 || coord_line !== 3'd0) begin errors++; $display("[TB] FAIL step4 got %0d/%0d want 4/0", coord_col, coord_line); end
        press_counts(1);
        checks++; if (coord_col !== 3'd0 || coord_line !== 3'd1) begin errors++; $display("[TB] FAIL step5 got %0d/%0d want 0/1", coord_col, coord_line); end
        press_counts(29);
        checks++; if (coord_col !== 3'd4 || coord_line !== 3'd6) begin errors++; $display("[TB] FAIL step34 got %0d/%0d want 4/6", coord_col, coord_line); end
        press_counts(1);
        checks++; if (coord_col !== 3'd0 || coord_line !== 3'd0) begin errors++; $display("[TB] FAIL step35 got %0d/%0d want 0/0", coord_col, coord_line); end
        button_count = 1'b0;
        tick(2);
        button_count = 1'b1;
        tick(10);
        checks++; if (coord_col !== 3'd0 || coord_line !== 3'd0) begin errors++; $display("[TB] FAIL glitch got %0d/%0d want 0/0", coord_col, coord_line); end
    endtask

    task automatic test_handshake();
        press_counts(17);
        checks++; if (coord_col !== 3'd2 || coord_line !== 3'd3) begin errors++; $display("[TB] FAIL goto17 got %0d/%0d want 2/3", coord_col, coord_line); end
        button_confirmation = 1'b0;
        tick(2 + DB);
        checks++; if (shot_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_early got %b want 0", shot_valid); end
        tick(1);
        checks++; if (shot_valid !== 1'b1 || shot_cell !== 6'd17) begin errors++; $display("[TB] FAIL valid_rise got %b cell %0d want 1 cell 17", shot_valid, shot_cell); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_wait got %b want 1", busy); end
        button_confirmation = 1'b1;
        for (int i = 0; i < 16; i++) begin
            button_count = (i < 8) ? 1'b0 : 1'b1;
            tick(1);
            checks++; if (shot_valid !== 1'b1 || shot_cell !== 6'd17) begin errors++; $display("[TB] FAIL hold_%0d got %b cell %0d want 1 cell 17", i, shot_valid, shot_cell); end
        end
        checks++; if (coord_col !== 3'd2 || coord_line !== 3'd3) begin errors++; $display("[TB] FAIL busy_count got %0d/%0d want 2/3", coord_col, coord_line); end
        shot_ready = 1'b1;
        tick(1);
        shot_ready = 1'b0;
        checks++; if (shot_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_fall got %b want 0", shot_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_release got %b want 1", busy); end
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_done got %b want 0", busy); end
    endtask

    task automatic test_duplicate();
        int dup_cnt = 0;
        int valid_cnt = 0;
        button_confirmation = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            dup_cnt += int'(dup_shot);
            valid_cnt += int'(shot_valid);
        end
        checks++; if (dup_cnt != 1) begin errors++; $display("[TB] FAIL dup_pulses got %0d want 1", dup_cnt); end
        checks++; if (valid_cnt != 0) begin errors++; $display("[TB] FAIL dup_valid got %0d want 0", valid_cnt); end
        button_confirmation = 1'b1;
        tick(8);
        hh1 = 2'b00;
        tick(5);
        checks++; if (coord_col !== 3'd0 || coord_line !== 3'd0) begin errors++; $display("[TB] FAIL idle_cursor got %0d/%0d want 0/0", coord_col, coord_line); end
        hh1 = 2'b10;
        tick(4);
        press_counts(17);
        button_confirmation = 1'b0;
        tick(3 + DB);
        checks++; if (shot_valid !== 1'b1 || shot_cell !== 6'd17) begin errors++; $display("[TB] FAIL reshot got %b cell %0d want 1 cell 17", shot_valid, shot_cell); end
        shot_ready = 1'b1;
        tick(1);
        shot_ready = 1'b0;
        button_confirmation = 1'b1;
        tick(8);
    endtask

    task automatic test_simultaneous();
        press_counts(1);
        button_count = 1'b0;
        button_confirmation = 1'b0;
        tick(3 + DB);
        checks++; if (shot_valid !== 1'b1 || shot_cell !== 6'd18) begin errors++; $display("[TB] FAIL simul_shot got %b cell %0d want 1 cell 18", shot_valid, shot_cell); end
        checks++; if (coord_col !== 3'd3 || coord_line !== 3'd3) begin errors++; $display("[TB] FAIL simul_cursor got %0d/%0d want 3/3", coord_col, coord_line); end
        button_count = 1'b1;
        button_confirmation = 1'b1;
        hh1 = 2'b01;
        tick(8);
        checks++; if (shot_valid !== 1'b1 || shot_cell !== 6'd18) begin errors++; $display("[TB] FAIL mode_hold got %b cell %0d want 1 cell 18", shot_valid, shot_cell); end
        shot_ready = 1'b1;
        tick(1);
        shot_ready = 1'b0;
        checks++; if (shot_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mode_exit valid %b busy %b want 0 0", shot_valid, busy); end
        checks++; if (coord_col !== 3'd0 || coord_line !== 3'd0) begin errors++; $display("[TB] FAIL mode_cursor got %0d/%0d want 0/0", coord_col, coord_line); end
    endtask

    task automatic test_back_to_back();
        int valid_cnt = 0;
        logic [5:0] cell_seen = 6'h3f;
        shot_ready = 1'b1;
        hh1 = 2'b10;
        tick(4);
        button_confirmation = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (shot_valid) begin
                valid_cnt++;
                cell_seen = shot_cell;
            end
        end
        checks++; if (valid_cnt != 1) begin errors++; $display("[TB] FAIL ready_high_cycles got %0d want 1", valid_cnt); end
        checks++; if (cell_seen !== 6'd0) begin errors++; $display("[TB] FAIL ready_high_cell got %0d want 0", cell_seen); end
        button_confirmation = 1'b1;
        shot_ready = 1'b0;
        tick(8);
    endtask

    task automatic test_clear_mid();
        press_counts(1);
        button_confirmation = 1'b0;
        tick(3 + DB);
        checks++; if (shot_valid !== 1'b1 || shot_cell !== 6'd1) begin errors++; $display("[TB] FAIL pre_clr got %b cell %0d want 1 cell 1", shot_valid, shot_cell); end
        clr = 1'b1;
        tick(1);
        checks++; if (shot_valid !== 1'b0 || shot_cell !== 6'd0 || coord_col !== 3'd0) begin errors++; $display("[TB] FAIL clr_mid valid %b cell %0d col %0d want 0 0 0", shot_valid, shot_cell, coord_col); end
        clr = 1'b0;
        button_confirmation = 1'b1;
        tick(4);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_cursor();
        test_handshake();
        test_duplicate();
        test_simultaneous();
        test_back_to_back();
        test_clear_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
